id_ex_register: RTL and testbench
=================================

# id_ex_register

ID/EX pipeline register of the 16-bit five-stage pipeline. It sits directly downstream of the decode-stage stall multiplexer. It captures the (possibly bubbled) control bundle together with decode data:
- register operands
- sign-extended immediate
- register addresses
- PC+1

It presents these to the execute stage. It supports flush (branch/jump squash) and hold (execute-stage freeze), tracks a per-entry valid bit, and keeps a saturating bubble counter for performance analysis.

## Interface
Parameters:
- DATA_W, 16, datapath width of operands, immediate, PC
- REG_AW, 3, register address width
- CNT_W, 16, bubble counter width

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  squash: next entry becomes a bubble
- hold  input  1  freeze: keep current contents
- clr_count  input  1  synchronous clear of bubble counter
- valid_in  input  1  decode slot holds a real instruction (0 when stall bubble inserted)
- reg_write_in, ALUSrc_in, MemWrite_in, MemRead_in, branch_in, jump_in  input  1 each  control from stall mux
- alu_control_in  input  3  ALU operation
- RegDst_in, MemToReg_in  input  2 each  destination / writeback select
- pc_plus1_in, read_data1_in, read_data2_in, imm_in  input  DATA_W each  decode data
- rs_in, rt_in, rd_in  input  REG_AW each  register addresses
- *_out (one per *_in above)  output  same widths  registered copies
- valid_out  output  1  EX slot holds a real instruction
- bubble_count  output  CNT_W  number of bubbles entered into EX since reset/clear

## Operation
- Priority per rising edge: rst (async) > flush > hold > load.
- Load (flush=0, hold=0): every *_out <= *_in; valid_out <= valid_in.
- Control gating on load: if valid_in=0, all control outputs load 0 regardless of their inputs. These are reg_write, alu_control, ALUSrc, RegDst, MemWrite, MemRead, MemToReg, branch and jump. Data fields load normally.
- Flush (flush=1, hold ignored):
  - all control outputs <= 0; valid_out <= 0
  - data/address outputs <= 0
- Hold (flush=0, hold=1): all outputs, including valid_out, retain their values. No input is sampled.
- Bubble counter:
  - increments by 1 on any edge where the newly captured entry is a bubble, i.e. a flush, or a load with valid_in=0
  - does not increment on hold
  - saturates at 2^CNT_W-1 (no wrap)
- clr_count=1: counter <= 0 on that edge. The clear takes priority over a simultaneous increment.
- The block generates no hazards itself. It only transports what decode produces.

## Timing
- Latency: exactly 1 cycle from input to output on load.
- Reset values (asserted asynchronously, immediately on rst rising, independent of clk): every output is 0, including valid_out and bubble_count.
- Reset mid-operation: all state is cleared within the same cycle. The first load occurs on the first rising clk edge after rst deasserts.
- Hold for N consecutive cycles keeps outputs constant for N cycles. The load resumes on the first edge with hold=0.
- flush and hold asserted on the same edge: flush result, the counter increments.
- A flush affects only the entry captured on that edge. The following edge loads normally.
- Counter at max with a bubble edge: it stays at max. Counter at max with clr_count: it becomes 0.

## Test plan
- Reset: assert rst mid-cycle with all inputs nonzero -> all outputs 0 immediately. After release, load read_data1_in=16'h1234, alu_control_in=3'b101, valid_in=1 -> next edge read_data1_out=16'h1234, alu_control_out=3'b101, valid_out=1.
- Bubble load: valid_in=0, reg_write_in=1, MemWrite_in=1, imm_in=16'hFFF0 -> reg_write_out=0, MemWrite_out=0, valid_out=0, imm_out=16'hFFF0, bubble_count=1.
- Flush: load a valid instruction (rd_in=3'd5, jump_in=1), then flush=1 -> rd_out=0, jump_out=0, valid_out=0, bubble_count increments by 1. Next edge with new valid input loads normally.
- Hold: capture read_data2_in=16'hABCD, then hold=1 for 3 edges while inputs change -> read_data2_out stays 16'hABCD and bubble_count is unchanged. hold=0 -> new value appears after 1 edge.
- Simultaneous flush+hold: both high with valid contents -> entry cleared, valid_out=0, counter +1.
- Counter saturation and clear: with CNT_W=4, drive 17 bubble edges -> bubble_count=4'hF. Then clr_count=1 together with a bubble edge -> bubble_count=0.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures the decode-stage control bundle and data for the
// execute stage. Supports flush (squash), hold (freeze), a per-entry valid bit and a
// saturating bubble counter.
module id_ex_register #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              clr_count,
    input  logic              valid_in,
    input  logic              reg_write_in,
    input  logic              ALUSrc_in,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              branch_in,
    input  logic              jump_in,
    input  logic [2:0]        alu_control_in,
    input  logic [1:0]        RegDst_in,
    input  logic [1:0]        MemToReg_in,
    input  logic [DATA_W-1:0] pc_plus1_in,
    input  logic [DATA_W-1:0] read_data1_in,
    input  logic [DATA_W-1:0] read_data2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_AW-1:0] rs_in,
    input  logic [REG_AW-1:0] rt_in,
    input  logic [REG_AW-1:0] rd_in,
    output logic              reg_write_out,
    output logic              ALUSrc_out,
    output logic              MemWrite_out,
    output logic              MemRead_out,
    output logic              branch_out,
    output logic              jump_out,
    output logic [2:0]        alu_control_out,
    output logic [1:0]        RegDst_out,
    output logic [1:0]        MemToReg_out,
    output logic [DATA_W-1:0] pc_plus1_out,
    output logic [DATA_W-1:0] read_data1_out,
    output logic [DATA_W-1:0] read_data2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_AW-1:0] rs_out,
    output logic [REG_AW-1:0] rt_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  bubble_count
);

    // A bubble enters EX on a flush, or on a load of an invalid decode slot.
    logic bubble_edge;
    logic count_at_max;

    // Bubble detection and counter saturation flag.
    always_comb begin
        bubble_edge  = flush | (~hold & ~valid_in);
        count_at_max = (bubble_count == {CNT_W{1'b1}});
    end

    // Pipeline entry: flush clears, hold freezes, otherwise load with control gated by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (flush && !rst)) begin
            reg_write_out   <= 1'b0;
            ALUSrc_out      <= 1'b0;
            MemWrite_out    <= 1'b0;
            MemRead_out     <= 1'b0;
            branch_out      <= 1'b0;
            jump_out        <= 1'b0;
            alu_control_out <= '0;
            RegDst_out      <= '0;
            MemToReg_out    <= '0;
            pc_plus1_out    <= '0;
            read_data1_out  <= '0;
            read_data2_out  <= '0;
            imm_out         <= '0;
            rs_out          <= '0;
            rt_out          <= '0;
            rd_out          <= '0;
            valid_out       <= 1'b0;
        end else if (!hold) begin
            reg_write_out   <= reg_write_in & valid_in;
            ALUSrc_out      <= ALUSrc_in & valid_in;
            MemWrite_out    <= MemWrite_in & valid_in;
            MemRead_out     <= MemRead_in & valid_in;
            branch_out      <= branch_in & valid_in;
            jump_out        <= jump_in & valid_in;
            alu_control_out <= valid_in ? alu_control_in : 3'b000;
            RegDst_out      <= valid_in ? RegDst_in : 2'b00;
            MemToReg_out    <= valid_in ? MemToReg_in : 2'b00;
            pc_plus1_out    <= pc_plus1_in;
            read_data1_out  <= read_data1_in;
            read_data2_out  <= read_data2_in;
            imm_out         <= imm_in;
            rs_out          <= rs_in;
            rt_out          <= rt_in;
            rd_out          <= rd_in;
            valid_out       <= valid_in;
        end
    end

    // Saturating bubble counter; a clear wins over a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (clr_count) begin
            bubble_count <= '0;
        end else if (bubble_edge && !count_at_max) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: a behavioural model pushes expected entries to a
// scoreboard queue as stimulus is applied; each scenario task pops and compares after the edge.
module tb_id_ex_register;

    typedef struct packed {
        logic        rw, asrc, mw, mr, br, jp;
        logic [2:0]  alu;
        logic [1:0]  rdst, m2r;
        logic [15:0] pc, rd1, rd2, imm;
        logic [2:0]  rs, rt, rd;
        logic        v;
        logic [3:0]  cnt;
    } out_t;

    logic        clk = 1'b0;
    logic        rst, flush, hold, clr_count, valid_in;
    logic        reg_write_in, ALUSrc_in, MemWrite_in, MemRead_in, branch_in, jump_in;
    logic [2:0]  alu_control_in;
    logic [1:0]  RegDst_in, MemToReg_in;
    logic [15:0] pc_plus1_in, read_data1_in, read_data2_in, imm_in;
    logic [2:0]  rs_in, rt_in, rd_in;
    logic        reg_write_out, ALUSrc_out, MemWrite_out, MemRead_out, branch_out, jump_out;
    logic [2:0]  alu_control_out;
    logic [1:0]  RegDst_out, MemToReg_out;
    logic [15:0] pc_plus1_out, read_data1_out, read_data2_out, imm_out;
    logic [2:0]  rs_out, rt_out, rd_out;
    logic        valid_out;
    logic [3:0]  bubble_count;

    int   total = 0;
    int   bad = 0;
    out_t mdl;
    out_t sb[$];
    out_t exp_e;
    out_t obs;

    id_ex_register #(.DATA_W(16), .REG_AW(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold), .clr_count(clr_count),
        .valid_in(valid_in), .reg_write_in(reg_write_in), .ALUSrc_in(ALUSrc_in),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .branch_in(branch_in),
        .jump_in(jump_in), .alu_control_in(alu_control_in), .RegDst_in(RegDst_in),
        .MemToReg_in(MemToReg_in), .pc_plus1_in(pc_plus1_in), .read_data1_in(read_data1_in),
        .read_data2_in(read_data2_in), .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in),
        .rd_in(rd_in), .reg_write_out(reg_write_out), .ALUSrc_out(ALUSrc_out),
        .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out), .branch_out(branch_out),
        .jump_out(jump_out), .alu_control_out(alu_control_out), .RegDst_out(RegDst_out),
        .MemToReg_out(MemToReg_out), .pc_plus1_out(pc_plus1_out),
        .read_data1_out(read_data1_out), .read_data2_out(read_data2_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .valid_out(valid_out),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    function automatic out_t dut_out();
        out_t o;
        o.rw = reg_write_out;     o.asrc = ALUSrc_out;  o.mw = MemWrite_out;
        o.mr = MemRead_out;       o.br = branch_out;    o.jp = jump_out;
        o.alu = alu_control_out;  o.rdst = RegDst_out;  o.m2r = MemToReg_out;
        o.pc = pc_plus1_out;      o.rd1 = read_data1_out;
        o.rd2 = read_data2_out;   o.imm = imm_out;
        o.rs = rs_out;            o.rt = rt_out;        o.rd = rd_out;
        o.v = valid_out;          o.cnt = bubble_count;
        return o;
    endfunction

    task automatic rand_inputs();
        reg_write_in = 1'($urandom);  ALUSrc_in = 1'($urandom);  MemWrite_in = 1'($urandom);
        MemRead_in = 1'($urandom);    branch_in = 1'($urandom);  jump_in = 1'($urandom);
        alu_control_in = 3'($urandom); RegDst_in = 2'($urandom); MemToReg_in = 2'($urandom);
        pc_plus1_in = 16'($urandom);  read_data1_in = 16'($urandom);
        read_data2_in = 16'($urandom); imm_in = 16'($urandom);
        rs_in = 3'($urandom);         rt_in = 3'($urandom);       rd_in = 3'($urandom);
    endtask

    // Model the next entry from current inputs, push it, then advance past the edge.
    task automatic tick();
        out_t n;
        logic bub;
        n = mdl;
        bub = flush | (!hold & !valid_in);
        if (flush) begin
            n = '0;
        end else if (!hold) begin
            n.rw = reg_write_in & valid_in;   n.asrc = ALUSrc_in & valid_in;
            n.mw = MemWrite_in & valid_in;    n.mr = MemRead_in & valid_in;
            n.br = branch_in & valid_in;      n.jp = jump_in & valid_in;
            n.alu = valid_in ? alu_control_in : 3'd0;
            n.rdst = valid_in ? RegDst_in : 2'd0;
            n.m2r = valid_in ? MemToReg_in : 2'd0;
            n.pc = pc_plus1_in;  n.rd1 = read_data1_in;  n.rd2 = read_data2_in;
            n.imm = imm_in;      n.rs = rs_in;  n.rt = rt_in;  n.rd = rd_in;
            n.v = valid_in;
        end
        if (clr_count) n.cnt = 4'd0;
        else if (bub && mdl.cnt != 4'hF) n.cnt = mdl.cnt + 4'd1;
        else n.cnt = mdl.cnt;
        mdl = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 0; hold = 0; clr_count = 0; valid_in = 1;
        rand_inputs();
        #1;
        total++;
        if (dut_out() !== out_t'(0)) begin
            bad++; $display("FAIL reset_initial: got %h want 0", dut_out());
        end
        @(negedge clk); rst = 1'b0; mdl = '0; sb.delete();
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e) begin bad++; $display("FAIL pre_reset_load: got %h want %h", obs, exp_e); end
        // Assert reset mid-cycle with nonzero inputs; outputs must clear at once.
        #2; rst = 1'b1; #1;
        total++;
        if (dut_out() !== out_t'(0)) begin
            bad++; $display("FAIL reset_async: got %h want 0", dut_out());
        end
        mdl = '0; sb.delete();
        @(negedge clk); rst = 1'b0;
        rand_inputs(); read_data1_in = 16'h1234; alu_control_in = 3'b101; valid_in = 1;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e) begin bad++; $display("FAIL first_load: got %h want %h", obs, exp_e); end
        total++;
        if (read_data1_out !== 16'h1234 || alu_control_out !== 3'b101 || valid_out !== 1'b1) begin
            bad++;
            $display("FAIL first_load_fields: got rd1=%h alu=%b v=%b want 1234 101 1",
                     read_data1_out, alu_control_out, valid_out);
        end
    endtask

    task automatic test_bubble_load();
        rand_inputs(); valid_in = 0; reg_write_in = 1; MemWrite_in = 1; imm_in = 16'hFFF0;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e) begin bad++; $display("FAIL bubble_load: got %h want %h", obs, exp_e); end
        total++;
        if (reg_write_out !== 0 || MemWrite_out !== 0 || valid_out !== 0 ||
            imm_out !== 16'hFFF0 || bubble_count !== 4'd1) begin
            bad++;
            $display("FAIL bubble_fields: got rw=%b mw=%b v=%b imm=%h cnt=%0d want 0 0 0 fff0 1",
                     reg_write_out, MemWrite_out, valid_out, imm_out, bubble_count);
        end
    endtask

    task automatic test_flush();
        logic [3:0] c0;
        rand_inputs(); valid_in = 1; rd_in = 3'd5; jump_in = 1;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e) begin bad++; $display("FAIL flush_pre: got %h want %h", obs, exp_e); end
        c0 = mdl.cnt;
        rand_inputs(); flush = 1;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e) begin bad++; $display("FAIL flush: got %h want %h", obs, exp_e); end
        total++;
        if (rd_out !== 0 || jump_out !== 0 || valid_out !== 0 || bubble_count !== c0 + 4'd1) begin
            bad++;
            $display("FAIL flush_fields: got rd=%0d jp=%b v=%b cnt=%0d want 0 0 0 %0d",
                     rd_out, jump_out, valid_out, bubble_count, c0 + 4'd1);
        end
        flush = 0; rand_inputs(); valid_in = 1;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e) begin bad++; $display("FAIL flush_after: got %h want %h", obs, exp_e); end
    endtask

    task automatic test_hold();
        logic [3:0] c0;
        rand_inputs(); valid_in = 1; read_data2_in = 16'hABCD;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e) begin bad++; $display("FAIL hold_capture: got %h want %h", obs, exp_e); end
        c0 = mdl.cnt;
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); valid_in = 1'($urandom);
            tick(); exp_e = sb.pop_front(); obs = dut_out();
            total++;
            if (obs !== exp_e || read_data2_out !== 16'hABCD || bubble_count !== c0) begin
                bad++;
                $display("FAIL hold_%0d: got %h want %h (rd2 want abcd, cnt want %0d)",
                         i, obs, exp_e, c0);
            end
        end
        hold = 0; rand_inputs(); valid_in = 1; read_data2_in = 16'h1357;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e || read_data2_out !== 16'h1357) begin
            bad++; $display("FAIL hold_release: got %h want %h", obs, exp_e);
        end
    endtask

    task automatic test_flush_hold();
        rand_inputs(); valid_in = 1;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e) begin bad++; $display("FAIL fh_pre: got %h want %h", obs, exp_e); end
        rand_inputs(); flush = 1; hold = 1;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e || valid_out !== 1'b0) begin
            bad++; $display("FAIL flush_hold: got %h want %h", obs, exp_e);
        end
        flush = 0; hold = 0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            rand_inputs(); valid_in = 0;
            tick(); exp_e = sb.pop_front(); obs = dut_out();
            total++;
            if (obs !== exp_e) begin bad++; $display("FAIL sat_%0d: got %h want %h", i, obs, exp_e); end
        end
        total++;
        if (bubble_count !== 4'hF) begin
            bad++; $display("FAIL saturate: got %h want f", bubble_count);
        end
        rand_inputs(); valid_in = 0; clr_count = 1;
        tick(); exp_e = sb.pop_front(); obs = dut_out();
        total++;
        if (obs !== exp_e || bubble_count !== 4'd0) begin
            bad++; $display("FAIL clear_at_max: got %h want %h", obs, exp_e);
        end
        clr_count = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            valid_in  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 5) == 0);
            hold      = ($urandom_range(0, 4) == 0);
            clr_count = ($urandom_range(0, 9) == 0);
            tick(); exp_e = sb.pop_front(); obs = dut_out();
            total++;
            if (obs !== exp_e) begin bad++; $display("FAIL rand_%0d: got %h want %h", i, obs, exp_e); end
        end
        flush = 0; hold = 0; clr_count = 0;
    endtask

    initial begin
        test_reset();
        test_bubble_load();
        test_flush();
        test_hold();
        test_flush_hold();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
